// File: rtl/board_frame_buffer.sv
// board_frame_buffer: double-buffered 4x4 tile store feeding the VGA reader.
// The game logic fills the back bank and requests a commit. The banks swap
// at the start of vsync. The new front is then copied into the new back.
// Optional macro BOARD_SWAP_COUNT_EN adds the swap_count output.
// Ports:
//   CLK100MHZ, reset      clock, synchronous active-high reset
//   vs                    vertical sync from the timing generator
//   rd_row, rd_col, data  display read address; registered tile out
//   wr_en, wr_row, wr_col, wr_data, wr_ready   back-bank write port
//   commit_req, busy, swapped                  bank swap control/status
//   swap_count            swaps performed (BOARD_SWAP_COUNT_EN only)
module board_frame_buffer #(
    parameter int DATA_W        = 17,
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              vs,
    input  logic [1:0]        rd_row,
    input  logic [1:0]        rd_col,
    output logic [DATA_W-1:0] data,
    input  logic              wr_en,
    input  logic [1:0]        wr_row,
    input  logic [1:0]        wr_col,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              commit_req,
    output logic              busy,
    output logic              swapped
`ifdef BOARD_SWAP_COUNT_EN
    ,
    output logic [15:0]       swap_count
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] COPY    = 2'd2;

    logic [1:0]        state;
    logic              front_sel;
    logic [3:0]        cnt;
    logic              vs_q;
    logic              vs_start;
    logic [3:0]        rd_idx;
    logic [3:0]        wr_idx;
    logic [DATA_W-1:0] bank [2][16];

    assign rd_idx = {rd_row, rd_col};
    assign wr_idx = {wr_row, wr_col};

    // Start of the sync pulse: the edge into the active level.
    assign vs_start = VS_ACTIVE_LOW ? (vs_q & ~vs) : (~vs_q & vs);

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                bank[0][i] <= '0;
                bank[1][i] <= '0;
            end
            front_sel <= 1'b0;
            state     <= IDLE;
            cnt       <= 4'd0;
            data      <= '0;
            swapped   <= 1'b0;
            // Park at the inactive level so release cannot fake an edge.
            vs_q      <= VS_ACTIVE_LOW;
`ifdef BOARD_SWAP_COUNT_EN
            swap_count <= 16'd0;
`endif
        end else begin
            vs_q    <= vs;
            data    <= bank[front_sel][rd_idx];
            swapped <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wr_en)
                        bank[~front_sel][wr_idx] <= wr_data;
                    if (commit_req)
                        state <= PENDING;
                end
                PENDING: begin
                    if (vs_start) begin
                        front_sel <= ~front_sel;
                        swapped   <= 1'b1;
                        cnt       <= 4'd0;
                        state     <= COPY;
`ifdef BOARD_SWAP_COUNT_EN
                        swap_count <= swap_count + 16'd1;
`endif
                    end
                end
                COPY: begin
                    // front_sel already points at the new front here.
                    bank[~front_sel][cnt] <= bank[front_sel][cnt];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_frame_buffer.sv
// tb_board_frame_buffer: scoreboard bench for board_frame_buffer.
// Directed test-plan sequences followed by randomized traffic.
module tb_board_frame_buffer;

    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vs = 1'b1;
    logic [1:0]    rd_row = '0;
    logic [1:0]    rd_col = '0;
    logic [DW-1:0] data;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_row = '0;
    logic [1:0]    wr_col = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          commit_req = 1'b0;
    logic          busy;
    logic          swapped;
    logic [15:0]   cnt_out;

    always #5 clk = ~clk;

    board_frame_buffer #(.DATA_W(DW), .VS_ACTIVE_LOW(1'b1)) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .vs        (vs),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .data      (data),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .commit_req(commit_req),
        .busy      (busy),
        .swapped   (swapped)
`ifdef BOARD_SWAP_COUNT_EN
        ,
        .swap_count(cnt_out)
`endif
    );
`ifndef BOARD_SWAP_COUNT_EN
    assign cnt_out = 16'd0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ready;
        logic          busy;
        logic          swapped;
        logic [15:0]   count;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: the displayed board and the board being edited.
    logic [DW-1:0] m_front [16];
    logic [DW-1:0] m_back  [16];
    int            m_mode = 0;   // 0 editing, 1 waiting for vsync, 2 copying
    int            m_left = 0;
    logic          m_vsq = 1'b1;
    logic [15:0]   m_swaps = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model one rising edge with the inputs now on the pins.
    task automatic step();
        exp_t e;
        logic vstart;
        logic [DW-1:0] tmp [16];
        int ri;
        int wi;
        ri = {rd_row, rd_col};
        wi = {wr_row, wr_col};
        vstart = m_vsq && !vs;
        e.swapped = 1'b0;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_front[i] = '0;
                m_back[i]  = '0;
            end
            m_mode = 0;
            m_left = 0;
            m_vsq = 1'b1;
            m_swaps = 0;
            e.data = '0;
        end else begin
            e.data = m_front[ri];
            m_vsq = vs;
            if (m_mode == 0) begin
                if (wr_en) m_back[wi] = wr_data;
                if (commit_req) m_mode = 1;
            end else if (m_mode == 1) begin
                if (vstart) begin
                    tmp = m_front;
                    m_front = m_back;
                    m_back = m_back;
                    m_mode = 2;
                    m_left = 16;
                    m_swaps = m_swaps + 16'd1;
                    e.swapped = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        e.ready = (m_mode == 0);
        e.busy  = (m_mode != 0);
`ifdef BOARD_SWAP_COUNT_EN
        e.count = m_swaps;
`else
        e.count = 16'd0;
`endif
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("data", 32'(data), 32'(e.data));
            chk("wr_ready", 32'(wr_ready), 32'(e.ready));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("swapped", 32'(swapped), 32'(e.swapped));
            chk("swap_count", 32'(cnt_out), 32'(e.count));
        end
    end

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic vs_pulse(int hi, int lo);
        vs = 1'b1;
        idle_cycles(hi);
        vs = 1'b0;
        idle_cycles(lo);
        vs = 1'b1;
    endtask

    task automatic write1(int r, int c, int v, bit commit);
        wr_en = 1'b1;
        wr_row = 2'(r);
        wr_col = 2'(c);
        wr_data = DW'(v);
        commit_req = commit;
        step();
        wr_en = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic read_at(int r, int c, int n);
        rd_row = 2'(r);
        rd_col = 2'(c);
        idle_cycles(n);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) read_at(i / 4, i % 4, 1);

        write1(2, 3, 2048, 1'b0);
        rd_row = 2'd2;
        rd_col = 2'd3;
        for (int f = 0; f < 3; f++) vs_pulse(20, 4);

        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        vs_pulse(100, 4);
        idle_cycles(30);

        write1(0, 0, 4, 1'b1);
        vs_pulse(10, 4);
        idle_cycles(20);
        read_at(0, 0, 2);
        read_at(2, 3, 2);

        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        idle_cycles(3);
        write1(1, 1, 8, 1'b1);
        vs_pulse(10, 4);
        idle_cycles(20);
        read_at(1, 1, 3);

        write1(3, 3, 77, 1'b1);
        vs_pulse(10, 1);
        vs = 1'b1;
        idle_cycles(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) read_at(i / 4, i % 4, 1);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 399) == 0);
            vs = ((n % 50) >= 46) ? 1'b0 : 1'b1;
            rd_row = 2'($urandom_range(0, 3));
            rd_col = 2'($urandom_range(0, 3));
            wr_en = ($urandom_range(0, 2) == 0);
            wr_row = 2'($urandom_range(0, 3));
            wr_col = 2'($urandom_range(0, 3));
            wr_data = DW'($urandom);
            commit_req = ($urandom_range(0, 19) == 0);
            step();
        end
        reset = 1'b0;
        wr_en = 1'b0;
        commit_req = 1'b0;

        for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
